stopwatch_time_core: RTL

- Timekeeping stage of the VGA stopwatch. Runs an 8-digit BCD time counter (HH:MM:SS:CC) under start/stop/clear control.
- Outputs each digit as a 7-bit segment pattern to the per-digit segment-to-pixel stage.
- Sits between the button front-end and the segment pixel-assignment instances, one instance per digit position 0..7.

---
 rtl/stopwatch_time_core_pkg.sv | 60 ++++++
 rtl/stopwatch_time_core_seg.sv | 28 ++
 rtl/stopwatch_time_core.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_time_core_pkg.sv
// Shared stopwatch definitions: FSM states, digit limits, segment patterns.
// Used by the time core and the per-digit segment/pixel stages.
package stopwatch_time_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Largest value a units digit / a minutes-or-seconds tens digit may hold
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  // Per-nibble limits of HH:MM:SS:CC, nibble 0 = centisecond units
  localparam logic [31:0] DIGIT_LIM = {
    DIGIT_MAX, DIGIT_MAX,
    TENS_MAX,  DIGIT_MAX,
    TENS_MAX,  DIGIT_MAX,
    DIGIT_MAX, DIGIT_MAX
  };

  // Button bit positions in the synchronizer vector
  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;
  localparam int BTN_LAP = 2;

  // Segment patterns, bit0 = a .. bit6 = g, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // One BCD digit step: returns {carry_out, next_digit}.
  // Values at or above the limit roll to zero so a corrupted
  // digit can never get stuck outside its legal range.
  function automatic logic [4:0] bcd_digit_step(
    input logic [3:0] d,
    input logic [3:0] lim,
    input logic       cin
  );
    logic [4:0] r;
    if (!cin) begin
      r = {1'b0, d};
    end else if (d >= lim) begin
      r = {1'b1, 4'd0};
    end else begin
      r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_time_core_seg.sv
// bcd_to_seven_seg: combinational BCD digit to 7-segment pattern.
// Codes 10..15 are shown blank.
module bcd_to_seven_seg
  import stopwatch_time_core_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Digit lookup
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_time_core.sv
// stopwatch_time_core: HH:MM:SS:CC BCD stopwatch with start/stop/clear.
// Define STOPWATCH_LAP_EN to add the lap-freeze display feature.
module stopwatch_time_core #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [31:0] bcd,
  output logic [55:0] seg,
  output logic        running,
  output logic        wrap
);

  import stopwatch_time_core_pkg::*;

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
  logic [NB-1:0] w_btn;
  assign w_btn = {btn_lap, btn_clear, btn_start_stop};
`else
  localparam int NB = 2;
  logic [NB-1:0] w_btn;
  logic          w_unused_lap;
  assign w_btn        = {btn_clear, btn_start_stop};
  assign w_unused_lap = btn_lap;
`endif

  logic [NB-1:0] r_meta;
  logic [NB-1:0] r_sync;
  logic [NB-1:0] r_hist;
  logic [NB-1:0] w_pulse;
  logic          w_ss;
  logic          w_clr_p;

  state_t        r_state;
  logic          r_running;
  logic [PW-1:0] r_pre;
  logic          w_tick;
  logic          w_clear;

  logic [31:0]   r_cnt;
  logic [31:0]   w_cnt_nxt;
  logic [4:0]    w_step;
  logic          w_cy;
  logic          w_roll;
  logic          r_wrap;

  logic [31:0]   w_bcd;
  logic [55:0]   w_seg;
  logic [55:0]   r_seg;

  // Two-flop synchronizer plus edge history for each button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      r_meta <= w_btn;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign w_pulse = r_sync & ~r_hist;
  assign w_ss    = w_pulse[BTN_SS];
  assign w_clr_p = w_pulse[BTN_CLR];

  // Clear only acts from PAUSE and then outranks start/stop
  assign w_clear = (r_state == ST_PAUSE) && w_clr_p;
  assign w_tick  = (r_state == ST_RUN) && (r_pre == PRE_MAX);

  // Control FSM; running follows the state it enters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_ss) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_ss) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (w_clr_p) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end else if (w_ss) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // Centisecond prescaler; holds its phase across PAUSE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (w_clear || (r_state == ST_IDLE)) begin
      r_pre <= '0;
    end else if (r_state == ST_RUN) begin
      if (r_pre == PRE_MAX) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

  // Ripple the tick through the eight BCD digits
  always_comb begin
    w_cy      = w_tick;
    w_cnt_nxt = r_cnt;
    w_step    = '0;
    for (int i = 0; i < 8; i++) begin
      w_step = bcd_digit_step(r_cnt[4*i +: 4],
                              DIGIT_LIM[4*i +: 4],
                              w_cy);
      w_cnt_nxt[4*i +: 4] = w_step[3:0];
      w_cy = w_step[4];
    end
    w_roll = w_cy;
  end

  // Time counter and full-rollover pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tick & w_roll;
      if (w_clear) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        r_lap_on;
  logic [31:0] r_lap;

  // Lap hold: toggled by lap presses in RUN, dropped on leaving RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lap_on <= 1'b0;
      r_lap    <= '0;
    end else if ((r_state != ST_RUN) || w_ss) begin
      r_lap_on <= 1'b0;
    end else if (w_pulse[BTN_LAP]) begin
      if (r_lap_on) begin
        r_lap_on <= 1'b0;
      end else begin
        r_lap_on <= 1'b1;
        r_lap    <= r_cnt;
      end
    end
  end

  assign w_bcd = r_lap_on ? r_lap : r_cnt;
`else
  assign w_bcd = r_cnt;
`endif

  for (genvar k = 0; k < 8; k++) begin : g_seg
    bcd_to_seven_seg u_seg (
      .i_bcd (w_bcd[4*(7-k) +: 4]),
      .o_seg (w_seg[7*k +: 7])
    );
  end

  // Segment register, one cycle behind bcd
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= {8{SEG_0}};
    end else begin
      r_seg <= w_seg;
    end
  end

  assign bcd     = w_bcd;
  assign seg     = r_seg;
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule
